// File: rtl/line_buffer_window_ctrl.sv
// Line-buffer controller: gates the two-row buffer from the pixel stream, tracks position,
// and emits qualified 3x3 interior windows built from the two taps and the live pixel.
module line_buffer_window_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 1280,
    parameter int unsigned IMG_HEIGHT = 720
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    input  logic                    s_sof,
    output logic [DATA_WIDTH-1:0]   sr_din,
    output logic                    sr_ce,
    input  logic [DATA_WIDTH-1:0]   sr_tap1,
    input  logic [DATA_WIDTH-1:0]   sr_tap0,
    output logic [9*DATA_WIDTH-1:0] win,
    output logic                    win_valid,
    output logic [10:0]             win_row,
    output logic [10:0]             win_col,
    output logic                    frame_done,
    output logic                    err_sof
);

    localparam int unsigned CW = 11;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] row_q, col_q;
    logic [CW-1:0] cur_row, cur_col;
    logic          at_row_end, at_frame_end;

    logic accept, qualify, done_d, err_d;

    // Each window row keeps the two previous columns; the third column is the live tap/pixel.
    logic [1:0][DATA_WIDTH-1:0] top_h, mid_h, bot_h;
    logic [9*DATA_WIDTH-1:0]    win_next;

    assign sr_din = s_data;
    assign sr_ce  = accept;

    // An accepted SOF pixel is position (0,0) regardless of the running counters.
    always_comb begin
        cur_row      = s_sof ? '0 : row_q;
        cur_col      = s_sof ? '0 : col_q;
        at_row_end   = (cur_col == COL_LAST);
        at_frame_end = at_row_end && (cur_row == ROW_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (s_sof) begin
                state_d = S_FILL;
            end else begin
                case (state_q)
                    S_FILL:  if ((cur_row == CW'(1)) && at_row_end) state_d = S_RUN;
                    S_RUN:   if (at_frame_end) state_d = S_IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // SOF landing exactly on the final pixel slot is a clean restart, not an error.
    always_comb begin
        accept  = s_valid && !rst && ((state_q != S_IDLE) || s_sof);
        qualify = accept && !s_sof
                  && ((state_q == S_RUN) || (state_d == S_RUN))
                  && (cur_row >= CW'(2)) && (cur_col >= CW'(2));
        done_d  = accept && !s_sof && (state_q == S_RUN) && at_frame_end;
        err_d   = accept && s_sof && (state_q != S_IDLE)
                  && !((row_q == ROW_LAST) && (col_q == COL_LAST));
    end

    always_comb begin
        win_next = {s_data,  bot_h[1], bot_h[0],
                    sr_tap1, mid_h[1], mid_h[0],
                    sr_tap0, top_h[1], top_h[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q      <= '0;
            col_q      <= '0;
            top_h      <= '0;
            mid_h      <= '0;
            bot_h      <= '0;
            win        <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
        end else begin
            win_valid  <= qualify;
            frame_done <= done_d;
            err_sof    <= err_d;
            if (accept) begin
                if (at_row_end) begin
                    col_q <= '0;
                    row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + CW'(1);
                end else begin
                    col_q <= cur_col + CW'(1);
                    row_q <= cur_row;
                end
                top_h <= {sr_tap0, top_h[1]};
                mid_h <= {sr_tap1, mid_h[1]};
                bot_h <= {s_data,  bot_h[1]};
            end
            if (qualify) begin
                win     <= win_next;
                win_row <= cur_row - CW'(1);
                win_col <= cur_col - CW'(1);
            end
        end
    end

endmodule
